// File: rtl/nes_pad_pkg.sv
// Shared NES pad definitions: FSM state encoding, button bit positions and frame length.
// Used by both the pad responder and the pad reader.
package nes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

    localparam int NES_BITS   = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_pad_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a single history flop
// that turns the synchronized level into one-cycle rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q[gi] <= 1'b0;
                end else if (gi == 0) begin
                    sync_q[gi] <= async_i;
                end else begin
                    sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/nes_pad_responder.sv
// Device side of the NES pad protocol: a CD4021-style parallel-load / serial-shift register
// driven by the host's latch and clock pins, presenting pressed buttons as 0 on the wire.
module nes_pad_responder
    import nes_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       latch_in,
    input  logic       pulse_in,
    input  logic [7:0] buttons,
    output logic       data_out,
    output logic [3:0] bit_cnt,
    output logic       frame_strobe,
    output logic       frame_done,
    output logic       overrun
);

    logic latch_level, latch_rise, latch_fall;
    logic pulse_level, pulse_rise, pulse_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (latch_in),
        .level_o (latch_level),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (pulse_in),
        .level_o (pulse_level),
        .rise_o  (pulse_rise),
        .fall_o  (pulse_fall)
    );

    // Only latch level/fall and clock rise drive the protocol.
    logic unused_sync;
    assign unused_sync = ^{latch_rise, pulse_level, pulse_fall};

    pad_state_t state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       strobe_q, strobe_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        // A high latch overrides everything, including a coincident clock edge.
        if (latch_level) begin
            state_d = LOAD;
            shreg_d = ~buttons;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (latch_fall) begin
                        state_d  = SHIFT;
                        strobe_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        shreg_d = {shreg_q[6:0], FILL_BIT};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'(NES_BITS - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (pulse_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= 8'hFF;
            cnt_q     <= 4'd0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out     = shreg_q[BTN_A];
    assign bit_cnt      = cnt_q;
    assign frame_strobe = strobe_q;
    assign frame_done   = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: emulates an NES host reading the pad and
// checks the serial bits against a queue of expected wire levels.
module tb_nes_pad_responder;

    localparam bit FILL = 1'b1;
    localparam int GAP  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       latch_in;
    logic       pulse_in;
    logic [7:0] buttons;
    logic       data_out;
    logic [3:0] bit_cnt;
    logic       frame_strobe;
    logic       frame_done;
    logic       overrun;

    int tests_run  = 0;
    int tests_fail = 0;
    int n_strobe   = 0;
    int n_done     = 0;
    int n_over     = 0;

    logic exp_q[$];

    nes_pad_responder #(.SYNC_STAGES(2), .FILL_BIT(FILL)) dut (
        .clk          (clk),
        .reset        (reset),
        .latch_in     (latch_in),
        .pulse_in     (pulse_in),
        .buttons      (buttons),
        .data_out     (data_out),
        .bit_cnt      (bit_cnt),
        .frame_strobe (frame_strobe),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_strobe) n_strobe++;
        if (frame_done)   n_done++;
        if (overrun)      n_over++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Expected wire image of a frame: pressed = 0, A first.
    task automatic push_frame(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(~b[i]);
    endtask

    task automatic host_latch(input logic [7:0] b);
        buttons  = b;
        latch_in = 1'b1;
        wait_cyc(GAP);
        latch_in = 1'b0;
        wait_cyc(GAP);
    endtask

    // Compare the bit the host would sample, then issue one clock pulse.
    task automatic host_clock(input string name);
        logic exp;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_fail++;
            $display("FAIL %s: scoreboard empty, data_out=%0b", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) begin
                tests_fail++;
                $display("FAIL %s: data_out=%0b expected %0b", name, data_out, exp);
            end else begin
                $display("[TB] %s: data_out=%0b ok", name, data_out);
            end
        end
        pulse_in = 1'b1;
        wait_cyc(GAP);
        pulse_in = 1'b0;
        wait_cyc(GAP);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        latch_in = 1'b0;
        pulse_in = 1'b0;
        buttons  = 8'h00;
        wait_cyc(3);
        tests_run++;
        if ({data_out, bit_cnt, frame_strobe, frame_done, overrun} !== {1'b1, 4'd0, 3'b000}) begin
            tests_fail++;
            $display("FAIL reset: data_out=%0b bit_cnt=%0d pulses=%0b%0b%0b expected 1 0 000",
                     data_out, bit_cnt, frame_strobe, frame_done, overrun);
        end else $display("[TB] reset: outputs ok");
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_frame();
        int s0, d0;
        s0 = n_strobe; d0 = n_done;
        exp_q.delete();
        host_latch(8'b1000_0001);
        push_frame(8'b1000_0001);
        tests_run++;
        if (n_strobe - s0 !== 1) begin
            tests_fail++;
            $display("FAIL frame_strobe: count=%0d expected 1", n_strobe - s0);
        end else $display("[TB] frame_strobe: count=1 ok");
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                tests_run++;
                if (n_done - d0 !== 0) begin
                    tests_fail++;
                    $display("FAIL early_done: count=%0d expected 0", n_done - d0);
                end
            end
            host_clock($sformatf("frame1_bit%0d", i));
        end
        tests_run++;
        if (n_done - d0 !== 1 || bit_cnt !== 4'd8) begin
            tests_fail++;
            $display("FAIL frame_done: count=%0d bit_cnt=%0d expected 1 8", n_done - d0, bit_cnt);
        end else $display("[TB] frame_done: count=1 bit_cnt=8 ok");
    endtask

    task automatic test_overrun();
        int o0, d0;
        o0 = n_over; d0 = n_done;
        exp_q.push_back(FILL);
        exp_q.push_back(FILL);
        host_clock("fill_bit9");
        host_clock("fill_bit10");
        tests_run++;
        if (n_over - o0 !== 2 || bit_cnt !== 4'd8 || n_done != d0 || data_out !== FILL) begin
            tests_fail++;
            $display("FAIL overrun: count=%0d bit_cnt=%0d done=%0d data_out=%0b expected 2 8 0 1",
                     n_over - o0, bit_cnt, n_done - d0, data_out);
        end else $display("[TB] overrun: count=2 bit_cnt=8 ok");
    endtask

    task automatic test_frozen();
        exp_q.delete();
        host_latch(8'hFF);
        push_frame(8'hFF);
        buttons = 8'h00;
        for (int i = 0; i < 8; i++) host_clock($sformatf("frozen_bit%0d", i));
    endtask

    task automatic test_relatch();
        int d0;
        exp_q.delete();
        host_latch(8'h3C);
        push_frame(8'h3C);
        for (int i = 0; i < 3; i++) host_clock($sformatf("abort_bit%0d", i));
        d0 = n_done;
        buttons  = 8'h5A;
        latch_in = 1'b1;
        wait_cyc(GAP);
        tests_run++;
        if (bit_cnt !== 4'd0 || n_done != d0) begin
            tests_fail++;
            $display("FAIL relatch: bit_cnt=%0d done=%0d expected 0 0", bit_cnt, n_done - d0);
        end else $display("[TB] relatch: bit_cnt=0 ok");
        latch_in = 1'b0;
        wait_cyc(GAP);
        exp_q.delete();
        push_frame(8'h5A);
        for (int i = 0; i < 8; i++) host_clock($sformatf("fresh_bit%0d", i));
        tests_run++;
        if (n_done - d0 !== 1) begin
            tests_fail++;
            $display("FAIL fresh_done: count=%0d expected 1", n_done - d0);
        end else $display("[TB] fresh_done: count=1 ok");
    endtask

    task automatic test_latch_wins();
        logic [7:0] pats [4] = '{8'h80, 8'h00, 8'h7F, 8'hC3};
        exp_q.delete();
        latch_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            buttons  = pats[i];
            pulse_in = 1'b1;
            wait_cyc(GAP);
            pulse_in = 1'b0;
            wait_cyc(GAP);
            tests_run++;
            if (data_out !== ~pats[i][7] || bit_cnt !== 4'd0) begin
                tests_fail++;
                $display("FAIL latch_wins%0d: data_out=%0b bit_cnt=%0d expected %0b 0",
                         i, data_out, bit_cnt, ~pats[i][7]);
            end else $display("[TB] latch_wins%0d: data_out=%0b ok", i, data_out);
        end
        latch_in = 1'b0;
        wait_cyc(GAP);
        push_frame(8'hC3);
        for (int i = 0; i < 8; i++) host_clock($sformatf("after_latch_bit%0d", i));
    endtask

    task automatic test_reset_midframe();
        int s0, d0, o0;
        exp_q.delete();
        host_latch(8'hA5);
        push_frame(8'hA5);
        for (int i = 0; i < 4; i++) host_clock($sformatf("pre_reset_bit%0d", i));
        s0 = n_strobe; d0 = n_done; o0 = n_over;
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(1);
        tests_run++;
        if ({data_out, bit_cnt, frame_strobe, frame_done, overrun} !== {1'b1, 4'd0, 3'b000}) begin
            tests_fail++;
            $display("FAIL midframe_reset: data_out=%0b bit_cnt=%0d pulses=%0b%0b%0b expected 1 0 000",
                     data_out, bit_cnt, frame_strobe, frame_done, overrun);
        end else $display("[TB] midframe_reset: outputs ok");
        reset = 1'b0;
        wait_cyc(2);
        // Idle ignores host clocks.
        for (int i = 0; i < 2; i++) begin
            pulse_in = 1'b1;
            wait_cyc(GAP);
            pulse_in = 1'b0;
            wait_cyc(GAP);
        end
        tests_run++;
        if (data_out !== 1'b1 || bit_cnt !== 4'd0 || n_strobe != s0 || n_done != d0 || n_over != o0) begin
            tests_fail++;
            $display("FAIL idle_ignores_clock: data_out=%0b bit_cnt=%0d pulses=%0d/%0d/%0d expected 1 0 0/0/0",
                     data_out, bit_cnt, n_strobe - s0, n_done - d0, n_over - o0);
        end else $display("[TB] idle_ignores_clock: ok");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_frozen();
        test_relatch();
        test_latch_wins();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
